// File: rtl/temp_uart_report_pkg.sv
// temp_uart_report_pkg: shared ASCII codes, FSM states, DS18B20 format constants
// and the double-dabble step used by the temperature report block.
package temp_uart_report_pkg;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD, S_SEND} state_t;

    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam int FRAC_BITS = 4;
    localparam int SIGN_BIT  = 15;
    localparam int LAST_CHAR = 8;

    // {hundreds, tens, units, binary}: add 3 to any digit >= 5, then shift left
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int i = 0; i < 3; i++)
            if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/temp_uart_report_uart_tx.sv
// temp_uart_report_uart_tx: 8N1 LSB-first UART transmitter; done pulses in the
// last cycle of the stop bit so the next start can follow with one idle cycle.
module temp_uart_report_uart_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic          r_busy;
    logic          r_tx;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [8:0]    r_frame;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_frame <= '0;
        end else if (!r_busy) begin
            if (i_start) begin
                r_busy  <= 1'b1;
                r_tx    <= 1'b0;
                r_frame <= {1'b1, i_data};
                r_cnt   <= '0;
                r_bit   <= '0;
            end
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
            if (r_bit == 4'd9) begin
                r_busy <= 1'b0;
                r_tx   <= 1'b1;
            end else begin
                r_bit   <= r_bit + 4'd1;
                r_tx    <= r_frame[0];
                r_frame <= {1'b1, r_frame[8:1]};
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tx   = r_tx;
    assign o_busy = r_busy;
    assign o_done = r_busy && (r_bit == 4'd9) && (r_cnt == LAST);

endmodule

// File: rtl/temp_uart_report.sv
// temp_uart_report: converts each raw DS18B20 sample to "sDDD.FC\r\n" and
// streams it over 8N1 UART; samples arriving mid-frame are dropped and flagged.
module temp_uart_report
    import temp_uart_report_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_temp_valid,
    input  logic [15:0] i_temp,
    output logic        o_busy,
    output logic        o_drop,
    output logic        o_tx
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    state_t      r_state, w_next;
    logic        r_sign;
    logic [3:0]  r_tenths;
    logic [19:0] r_dd;
    logic [2:0]  r_cnt;
    logic [3:0]  r_idx;
    logic        r_drop;

    logic [11:0] w_mag;
    logic [7:0]  w_prod;
    logic        w_start;
    logic [7:0]  w_char;
    logic        w_done;
    logic        w_tx_busy;
    logic        w_unused;

    // low 12 bits of the two's-complement negation depend only on the low 12 input bits
    assign w_mag    = i_temp[SIGN_BIT] ? (~i_temp[11:0] + 12'd1) : i_temp[11:0];
    assign w_prod   = {1'b0, w_mag[FRAC_BITS-1:0], 3'b000} + {3'b000, w_mag[FRAC_BITS-1:0], 1'b0};
    assign w_unused = ^{i_temp[14:12], w_prod[3:0], w_tx_busy};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            S_IDLE: if (i_temp_valid) w_next = S_CONV;
            S_CONV: if (r_cnt == 3'd7) w_next = S_LOAD;
            S_LOAD: begin
                w_start = 1'b1;
                w_next  = S_SEND;
            end
            S_SEND: if (w_done) w_next = (r_idx == 4'(LAST_CHAR)) ? S_IDLE : S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sign   <= 1'b0;
            r_tenths <= '0;
            r_dd     <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= i_temp_valid && (r_state != S_IDLE);
            if (r_state == S_IDLE && i_temp_valid) begin
                r_sign   <= i_temp[SIGN_BIT];
                r_tenths <= w_prod[7:4];
                r_dd     <= {12'd0, w_mag[11:4]};
                r_cnt    <= '0;
            end
            if (r_state == S_CONV) begin
                r_dd  <= dd_step(r_dd);
                r_cnt <= r_cnt + 3'd1;
            end
            if (r_state == S_SEND && w_done)
                r_idx <= (r_idx == 4'(LAST_CHAR)) ? 4'd0 : r_idx + 4'd1;
        end
    end

    always_comb begin
        w_char = ASCII_LF;
        case (r_idx)
            4'd0: w_char = r_sign ? ASCII_MINUS : ASCII_PLUS;
            4'd1: w_char = ASCII_ZERO + {4'h0, r_dd[19:16]};
            4'd2: w_char = ASCII_ZERO + {4'h0, r_dd[15:12]};
            4'd3: w_char = ASCII_ZERO + {4'h0, r_dd[11:8]};
            4'd4: w_char = ASCII_DOT;
            4'd5: w_char = ASCII_ZERO + {4'h0, r_tenths};
            4'd6: w_char = ASCII_C;
            4'd7: w_char = ASCII_CR;
            default: w_char = ASCII_LF;
        endcase
    end

    temp_uart_report_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_start),
        .i_data  (w_char),
        .o_tx    (o_tx),
        .o_busy  (w_tx_busy),
        .o_done  (w_done)
    );

    assign o_busy = (r_state != S_IDLE);
    assign o_drop = r_drop;

endmodule

// File: tb/tb_temp_uart_report.sv
// tb_temp_uart_report: directed samples; expected text is queued at strobe time
// and a mid-bit UART monitor pops and compares each received character.
module tb_temp_uart_report;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        temp_valid = 1'b0;
    logic [15:0] temp = '0;
    logic        busy, drop, tx;

    int n_chk = 0;
    int n_fail = 0;
    int drop_cnt = 0;
    logic [7:0] exp_q[$];

    int         rx_t;
    bit         rx_on = 1'b0;
    logic [7:0] rx_byte;

    temp_uart_report #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_temp_valid (temp_valid),
        .i_temp       (temp),
        .o_busy       (busy),
        .o_drop       (drop),
        .o_tx         (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART receiver: start seen at t=0, bit k sampled mid-bit at t=16k+8
    always @(negedge clk) begin
        if (!rst_n) rx_on = 1'b0;
        else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == CPB / 2) begin
                if (rx_t / CPB == 0) check("start_bit", {31'd0, tx}, 32'd0);
                else if (rx_t / CPB <= 8) rx_byte[rx_t / CPB - 1] = tx;
                else begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_char: got %0h expected none", rx_byte);
                    end else check("char", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                    rx_on = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) if (drop === 1'b1) drop_cnt++;

    task automatic expect_text(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic strobe(input logic [15:0] t);
        temp_valid = 1'b1;
        temp = t;
        @(posedge clk); #1;
        temp_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] t, input string s);
        expect_text(s);
        strobe(t);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!busy) return;
        end
        check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_lo, t_hi, t_busy;
        #12;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_drop", {31'd0, drop}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // valid sampled at edge S: start bit from S+9 (i=9), 16 cycles wide,
        // busy falls 9*161-1 edges after that start edge (i=9+1448=1457)
        send(16'h0191, "+025.0C");
        check("busy_after_capture", {31'd0, busy}, 32'd1);
        t_lo = -1; t_hi = -1; t_busy = -1;
        for (int i = 1; i <= 3000 && t_busy < 0; i++) begin
            @(posedge clk); #1;
            if (t_lo < 0 && !tx) t_lo = i;
            else if (t_lo >= 0 && t_hi < 0 && tx) t_hi = i;
            if (!busy) t_busy = i;
        end
        check("start_latency", t_lo, 32'd9);
        check("start_width", t_hi - t_lo, CPB);
        check("busy_fall", t_busy, 32'd1457);

        send(16'hFF5E, "-010.1C"); wait_idle("neg_10_1");
        send(16'hFC90, "-055.0C"); wait_idle("neg_55");
        send(16'h07D0, "+125.0C"); wait_idle("pos_125");
        send(16'h0008, "+000.5C"); wait_idle("pos_0_5");
        check("no_drop_yet", drop_cnt, 32'd0);

        send(16'h0151, "+021.0C");
        repeat (20) @(posedge clk);
        #1;
        strobe(16'h0191);
        check("drop_pulse", {31'd0, drop}, 32'd1);
        @(posedge clk); #1;
        check("drop_one_cycle", {31'd0, drop}, 32'd0);
        wait_idle("drop_frame");

        send(16'h0191, "+025.0C"); wait_idle("b2b_first");
        send(16'h0008, "+000.5C");
        check("b2b_accepted", {31'd0, busy}, 32'd1);
        wait_idle("b2b_second");

        // char 3 ('5'=0x35) starts at i=9+3*161=492; its bit d1 (0) spans i=524..539
        send(16'hFC90, "-055.0C");
        repeat (531) @(posedge clk);
        #3;
        check("tx_low_before_reset", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_tx", {31'd0, tx}, 32'd1);
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(16'h0000, "+000.0C"); wait_idle("zero");
        send(16'hFFFF, "-000.0C"); wait_idle("minus_lsb");
        send(16'h8000, "-000.0C"); wait_idle("most_neg");

        repeat (20) @(posedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        check("drop_total", drop_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
